// File: rtl/mouse_pkg.sv
// mouse_pkg: shared receiver state type, error codes and default timeout
package mouse_pkg;
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DONE} rx_state_t;
  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_PARITY = 2'b01;
  localparam logic [1:0] ERR_STOP   = 2'b10;
  localparam int TIMEOUT_CYCLES_DEF = 50000;
endpackage

// File: rtl/mouse_receiver_if.sv
// mouse_receiver_if: PS/2 line inputs, read enable and received-byte handover
//   master: mouse master SM side (drives lines/READ_ENABLE, consumes bytes)
//   slave : receiver side
interface mouse_receiver_if;
  logic       CLK_MOUSE_IN;
  logic       DATA_MOUSE_IN;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  modport master (output CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
                  input  BYTE_READ, BYTE_ERROR_CODE, BYTE_READY);
  modport slave  (input  CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
                  output BYTE_READ, BYTE_ERROR_CODE, BYTE_READY);
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: two-flop synchroniser + registered falling-edge pulse for a PS/2 clock/data pair
//   i_clk_line/i_data_line: raw async lines; o_clk_fall: one-cycle pulse; o_sync_data: data aligned to o_clk_fall
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clk_line,
  input  logic i_data_line,
  output logic o_sync_data,
  output logic o_clk_fall
);
  logic [2:0] r_clk_sh;
  logic [1:0] r_data_sh;
  logic       r_data;
  logic       r_fall;
  // r_clk_sh[1] is the synchronised clock, r_clk_sh[2] its history; data is delayed one extra flop to stay aligned with the registered fall pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_clk_sh  <= 3'b111;
      r_data_sh <= 2'b11;
      r_data    <= 1'b1;
      r_fall    <= 1'b0;
    end else begin
      r_clk_sh  <= {r_clk_sh[1:0], i_clk_line};
      r_data_sh <= {r_data_sh[0], i_data_line};
      r_data    <= r_data_sh[1];
      r_fall    <= r_clk_sh[2] & ~r_clk_sh[1];
    end
  assign o_sync_data = r_data;
  assign o_clk_fall  = r_fall;
endmodule

// File: rtl/mouse_receiver.sv
// mouse_receiver: PS/2 device-to-host frame deserialiser with parity/stop checking and timeout
//   CLK/RESET (async active-low); bus.slave: mouse lines, READ_ENABLE in; BYTE_READ/BYTE_ERROR_CODE/BYTE_READY out
module mouse_receiver
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  mouse_receiver_if.slave  bus
);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic             w_data;
  logic             w_fall;
  rx_state_t        r_state;
  logic [7:0]       r_shift;
  logic [3:0]       r_bit_cnt;
  logic             r_parity;
  logic [CNT_W-1:0] r_to_cnt;
  logic [7:0]       r_byte;
  logic [1:0]       r_err;
  logic             r_ready;
  ps2_line_sync u_sync (
    .clk         (CLK),
    .rst_n       (RESET),
    .i_clk_line  (bus.CLK_MOUSE_IN),
    .i_data_line (bus.DATA_MOUSE_IN),
    .o_sync_data (w_data),
    .o_clk_fall  (w_fall)
  );
  // Outputs are loaded on the stop-bit fall so they are valid during the single DONE cycle
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      r_state   <= IDLE;
      r_shift   <= 8'h00;
      r_bit_cnt <= 4'd0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
      r_byte    <= 8'h00;
      r_err     <= ERR_NONE;
      r_ready   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          r_to_cnt <= '0;
          if (w_fall && bus.READ_ENABLE && !w_data) begin
            r_state   <= DATA;
            r_bit_cnt <= 4'd0;
          end
        end
        DATA, PARITY, STOP:
          if (w_fall) begin
            r_to_cnt <= '0;
            if (r_state == DATA) begin
              r_shift   <= {w_data, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) r_state <= PARITY;
            end else if (r_state == PARITY) begin
              r_parity <= w_data;
              r_state  <= STOP;
            end else begin
              r_byte  <= r_shift;
              r_err   <= ((^r_shift ^ r_parity) ? ERR_NONE : ERR_PARITY) | (w_data ? ERR_NONE : ERR_STOP);
              r_ready <= 1'b1;
              r_state <= DONE;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_state  <= IDLE;
            r_to_cnt <= '0;
          end else
            r_to_cnt <= r_to_cnt + 1'b1;
        default: begin
          r_to_cnt <= '0;
          r_state  <= IDLE;
        end
      endcase
    end
  assign bus.BYTE_READ       = r_byte;
  assign bus.BYTE_ERROR_CODE = r_err;
  assign bus.BYTE_READY      = r_ready;
endmodule

// File: tb/tb_mouse_receiver.sv
// tb_mouse_receiver: directed PS/2 frames with immediate-assertion checks (timing scaled: 40-clock bits, 200-clock timeout)
module tb_mouse_receiver;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   cyc = 0;
  int   n_strobe = 0;
  int   strobe_cyc = 0;
  int   fall_cyc = 0;
  int   n_asserts = 0;
  int   n_fail = 0;
  int   base;
  mouse_receiver_if bus ();
  mouse_receiver #(.TIMEOUT_CYCLES(200), .CNT_W(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );
  always #10 CLK = ~CLK;
  always @(posedge CLK) cyc++;
  always @(negedge CLK)
    if (bus.BYTE_READY === 1'b1) begin
      n_strobe++;
      strobe_cyc = cyc;
    end
  task automatic ticks(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    bus.DATA_MOUSE_IN = b;
    ticks(10);
    bus.CLK_MOUSE_IN = 1'b0;
    fall_cyc = cyc;
    ticks(20);
    bus.CLK_MOUSE_IN = 1'b1;
    ticks(10);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic drop_re);
    send_bit(1'b0);
    if (drop_re) bus.READ_ENABLE = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    bus.DATA_MOUSE_IN = 1'b1;
    ticks(10);
  endtask
  task automatic chk_frame(input string tag, input logic [7:0] b, input logic [1:0] e, input int cnt);
    chk({tag, "_byte"}, bus.BYTE_READ, b);
    chk({tag, "_err"}, bus.BYTE_ERROR_CODE, e);
    chk({tag, "_strobes"}, n_strobe, cnt);
  endtask
  initial begin
    bus.CLK_MOUSE_IN  = 1'b1;
    bus.DATA_MOUSE_IN = 1'b1;
    bus.READ_ENABLE   = 1'b1;
    ticks(3);
    chk("rst_byte", bus.BYTE_READ, 8'h00);
    chk("rst_err", bus.BYTE_ERROR_CODE, 2'b00);
    chk("rst_ready", bus.BYTE_READY, 1'b0);
    RESET = 1'b1;
    ticks(5);
    send_frame(8'hFA, 1'b1, 1'b1, 1'b0);
    chk_frame("fa", 8'hFA, 2'b00, 1);
    chk("fa_latency", strobe_cyc - fall_cyc, 4);
    send_frame(8'hAA, 1'b1, 1'b1, 1'b0);
    chk_frame("aa", 8'hAA, 2'b00, 2);
    send_frame(8'h00, 1'b1, 1'b1, 1'b0);
    chk_frame("b2b_00", 8'h00, 2'b00, 3);
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    chk_frame("par_err", 8'h00, 2'b01, 4);
    send_frame(8'h03, 1'b1, 1'b0, 1'b0);
    chk_frame("stop_err", 8'h03, 2'b10, 5);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    bus.DATA_MOUSE_IN = 1'b1;
    ticks(300);
    chk("abort_no_strobe", n_strobe, 5);
    send_frame(8'h03, 1'b1, 1'b1, 1'b0);
    chk_frame("after_abort", 8'h03, 2'b00, 6);
    bus.READ_ENABLE = 1'b0;
    send_frame(8'hFA, 1'b1, 1'b1, 1'b0);
    chk("re0_no_strobe", n_strobe, 6);
    chk("re0_byte_held", bus.BYTE_READ, 8'h03);
    bus.READ_ENABLE = 1'b1;
    send_frame(8'hF4, 1'b0, 1'b1, 1'b1);
    chk_frame("re_drop", 8'hF4, 2'b00, 7);
    bus.READ_ENABLE = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    RESET = 1'b0;
    ticks(2);
    chk("midrst_byte", bus.BYTE_READ, 8'h00);
    chk("midrst_err", bus.BYTE_ERROR_CODE, 2'b00);
    chk("midrst_ready", bus.BYTE_READY, 1'b0);
    RESET = 1'b1;
    ticks(300);
    chk("midrst_no_strobe", n_strobe, 7);
    base = n_strobe;
    send_frame(8'hFA, 1'b1, 1'b1, 1'b0);
    chk_frame("post_rst", 8'hFA, 2'b00, base + 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/mouse_receiver.md
Name: mouse_receiver

Overview:
PS/2 host-side serial receiver for the mouse interface. It sits directly upstream of the mouse master state machine and feeds it. It deserialises 11-bit device-to-host frames from the mouse clock/data lines into bytes. It hands each byte over with a one-cycle ready strobe and a 2-bit error code, gated by the master's read enable.

Parameters:
TIMEOUT_CYCLES, 50000, system clocks allowed between consecutive mouse-clock falling edges inside a frame (1 ms at 50 MHz) before the frame is abandoned
CNT_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
CLK  in  1  system clock, 50 MHz
RESET  in  1  asynchronous, active-low reset (0 = reset)
CLK_MOUSE_IN  in  1  PS/2 clock line, asynchronous to CLK
DATA_MOUSE_IN  in  1  PS/2 data line, asynchronous to CLK
READ_ENABLE  in  1  from master SM; frames start only while high
BYTE_READ  out  8  last received data byte
BYTE_ERROR_CODE  out  2  bit0 = parity error, bit1 = stop-bit error
BYTE_READY  out  1  one-cycle strobe: BYTE_READ and BYTE_ERROR_CODE valid

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE, BYTE_READ=8'h00, BYTE_ERROR_CODE=2'b00, BYTE_READY=0, bit counter=0, timeout counter=0, synchroniser flops=1. Reset mid-frame discards the partial frame and produces no strobe.
- Synchronisation: both lines pass through two flops plus one history flop. fall = prev & ~sync is a one-cycle pulse. Pin-to-fall latency is 3 CLK cycles. Data is sampled from the synchronised data line in the fall cycle.
- States: IDLE, DATA, PARITY, STOP, DONE.
- IDLE: on fall with READ_ENABLE=1 and data=0 (start bit), go to DATA with bit count 0. A fall with data=1 is a glitch: stay in IDLE. All falls are ignored while READ_ENABLE=0.
- DATA: on each fall, shift data in LSB-first into the shift register and increment the count. After the 8th bit, go to PARITY.
- PARITY: on fall, capture the parity bit and go to STOP.
- STOP: on fall, capture the stop bit and go to DONE.
- DONE (1 cycle): load BYTE_READ from the shift register. Set BYTE_ERROR_CODE[0] = 1 unless (XOR of 8 data bits ^ parity) == 1 (odd parity). Set BYTE_ERROR_CODE[1] = ~stop bit. Assert BYTE_READY for exactly this cycle, then return to IDLE.
- BYTE_READY latency: high on the cycle after the stop-bit fall pulse.
- BYTE_READ and BYTE_ERROR_CODE hold their values until the next DONE. Errored bytes are still delivered with a strobe.
- READ_ENABLE is sampled only in IDLE. Deasserting it mid-frame does not abort; the frame completes and strobes.
- Timeout: in DATA, PARITY and STOP, the counter clears on every fall and increments otherwise. When it reaches TIMEOUT_CYCLES-1, return to IDLE with no strobe and outputs unchanged. The counter is held at 0 in IDLE and DONE.
- The counter saturates and never wraps. The bit counter is 4 bits and never exceeds 8.

Decomposition:
- Shared package mouse_pkg: receiver state enum; error code constants ERR_NONE=2'b00, ERR_PARITY=2'b01, ERR_STOP=2'b10; default TIMEOUT_CYCLES.
- Sub-module ps2_line_sync: two-flop synchroniser plus falling-edge detector for one line pair (clock, data). It outputs sync_data and clk_fall, and is reusable by the transmitter.

Test Plan:
- READ_ENABLE=1, frame 0xFA (bits 0,1,0,1,1,1,1,1; parity 1; stop 1) at 10 kHz -> one BYTE_READY pulse, BYTE_READ=8'hFA, BYTE_ERROR_CODE=2'b00; strobe is 4 CLKs after the final pin falling edge.
- Back-to-back frames 0xAA (parity 1) then 0x00 (parity 1) -> two strobes: AA/00, then 00/00.
- Frame 0x00 with parity 0 -> BYTE_READ=8'h00, code 2'b01. Frame 0x03 with parity 1 and stop 0 -> code 2'b10.
- Frame aborted after 5 data bits, lines idle for 60000 CLKs, then a valid 0x03 frame -> no strobe for the partial frame; next strobe shows BYTE_READ=8'h03, code 00.
- READ_ENABLE=0 during a full 0xFA frame -> no strobe and BYTE_READ unchanged. READ_ENABLE dropped after the start bit of 0xF4 -> strobe with 8'hF4.
- RESET pulsed low mid-frame (after 4 bits), then a full 0xFA frame -> outputs 00/00/0 during reset, no strobe for the partial frame, then a clean FA strobe.
